// File: rtl/iob_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iob_sram_arbiter
// Brief    : Two-master IOb arbiter/sequencer for RW port 0 of the sky130
//            1rw1r SRAM macro. Define SRAM_ARB_FIXED_PRIO_EN for fixed p0
//            priority; round-robin otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module iob_sram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_valid,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [DATA_W/8-1:0]   p0_wstrb,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_ready,
    input  logic                  p1_valid,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [DATA_W/8-1:0]   p1_wstrb,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_ready,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [DATA_W/8-1:0]   sram_wmask0,
    output logic [ADDR_W-1:0]     sram_addr0,
    output logic [DATA_W-1:0]     sram_din0,
    input  logic [DATA_W-1:0]     sram_dout0,
    output logic                  busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 3;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              csb0_q, csb0_d;
    logic              web0_q, web0_d;
    logic [STRB_W-1:0] wmask0_q, wmask0_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [DATA_W-1:0] din0_q, din0_d;
    logic              p0_ready_q, p0_ready_d;
    logic              p1_ready_q, p1_ready_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              busy_q, busy_d;

    logic              w_any;
    logic              w_win;
    logic [STRB_W-1:0] w_win_strb;

    assign w_any      = p0_valid | p1_valid;
    assign w_win_strb = w_win ? p1_wstrb : p0_wstrb;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign w_win = ~p0_valid;
`else
    logic last_grant_q, last_grant_d;

    // A tie goes to whoever was not served last.
    assign w_win = (p0_valid & p1_valid) ? ~last_grant_q : ~p0_valid;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == c_st_idle && w_any) begin
            last_grant_d = w_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:   if (w_any) state_d = c_st_access;
            c_st_access: state_d = (|wmask0_q) ? c_st_resp : c_st_wait;
            c_st_wait:   if (cnt_q == '0) state_d = c_st_resp;
            c_st_resp:   state_d = c_st_idle;
            default:     state_d = c_st_idle;
        endcase
    end

    // Next values for every registered output; the macro pins are set one
    // edge ahead so that ACCESS sees them for its whole cycle.
    always_comb begin
        csb0_d     = 1'b1;
        web0_d     = 1'b1;
        wmask0_d   = wmask0_q;
        addr0_d    = addr0_q;
        din0_d     = din0_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        busy_d     = (state_d != c_st_idle);
        p0_ready_d = (state_d == c_st_resp) && !grant_q;
        p1_ready_d = (state_d == c_st_resp) &&  grant_q;
        case (state_q)
            c_st_idle: begin
                if (w_any) begin
                    grant_d  = w_win;
                    csb0_d   = 1'b0;
                    web0_d   = ~|w_win_strb;
                    wmask0_d = w_win_strb;
                    addr0_d  = w_win ? p1_addr  : p0_addr;
                    din0_d   = w_win ? p1_wdata : p0_wdata;
                end
            end
            c_st_access: cnt_d = c_wait_load;
            c_st_wait: begin
                if (cnt_q == '0) begin
                    if (grant_q) p1_rdata_d = sram_dout0;
                    else         p0_rdata_d = sram_dout0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= 1'b0;
            cnt_q      <= '0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            wmask0_q   <= '0;
            addr0_q    <= '0;
            din0_q     <= '0;
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            csb0_q     <= csb0_d;
            web0_q     <= web0_d;
            wmask0_q   <= wmask0_d;
            addr0_q    <= addr0_d;
            din0_q     <= din0_d;
            p0_ready_q <= p0_ready_d;
            p1_ready_q <= p1_ready_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign sram_csb0   = csb0_q;
    assign sram_web0   = web0_q;
    assign sram_wmask0 = wmask0_q;
    assign sram_addr0  = addr0_q;
    assign sram_din0   = din0_q;
    assign p0_ready    = p0_ready_q;
    assign p1_ready    = p1_ready_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire
